// File: rtl/dcache_load_responder.sv
// ---------------------------------------------------------------------------
// dcache_load_responder
//
// Responder side of the load-unit / D-cache handshake. Accepts one blocking
// BUS_LOAD request at a time, looks it up in a direct-mapped cache of 8-byte
// blocks, and answers with size-extracted, right-aligned data together with a
// one-cycle finish pulse. Misses are filled from main memory over a tagged
// bus: the fill request is held until memory returns a nonzero transaction
// tag, and the fill completes when data carrying that tag comes back.
//
// Ports
//   clock               in   1     system clock
//   reset               in   1     asynchronous, active-low reset
//   proc2Dcache_command in   2     BUS_NONE / BUS_LOAD (other codes ignored)
//   proc2Dcache_addr    in   XLEN  byte address of the load
//   load_mem_size       in   3     [1:0] BYTE/HALF/WORD/DOUBLE, [2] unsigned
//   Dcache2proc_data    out  64    loaded value, extended to 64 bits
//   finish              out  1     one-cycle pulse qualifying Dcache2proc_data
//   proc2mem_command    out  2     BUS_LOAD while requesting a fill
//   proc2mem_addr       out  XLEN  block-aligned fill address
//   mem2proc_response   in   4     nonzero = fill accepted, value = txn tag
//   mem2proc_data       in   64    fill data
//   mem2proc_tag        in   4     tag of mem2proc_data, 0 = nothing
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module dcache_load_responder #(
  parameter int NUM_LINES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        proc2Dcache_command,
  input  logic [`XLEN-1:0]  proc2Dcache_addr,
  input  logic [2:0]        load_mem_size,
  output logic [63:0]       Dcache2proc_data,
  output logic              finish,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag
);

  localparam int XLEN  = `XLEN;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESP
  } state_t;

  state_t              state_reg;
  logic [XLEN-1:0]     addr_reg;
  logic [2:0]          size_reg;
  logic [3:0]          txn_tag_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic                finish_reg;
  logic [63:0]         data_reg;
  logic [1:0]          mem_cmd_reg;
  logic [XLEN-1:0]     mem_addr_reg;

  // Tag and data storage. Only the valid bits need clearing on reset, so the
  // arrays themselves carry no reset. They are read combinationally so that a
  // hit can be answered in the cycle right after the request.
  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [63:0]      data_mem [NUM_LINES];

  // Incoming request fields
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_hit;

  // Latched request fields (used while filling)
  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             fill_match;

  assign req_idx = proc2Dcache_addr[3 +: IDX_W];
  assign req_tag = proc2Dcache_addr[XLEN-1 -: TAG_W];
  assign req_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);

  assign lat_idx = addr_reg[3 +: IDX_W];
  assign lat_tag = addr_reg[XLEN-1 -: TAG_W];

  // Tag 0 means "no data on the bus"; because the transaction tag is cleared
  // to 0 on reset and after every fill, stale returns can never match.
  assign fill_match = (mem2proc_tag != 4'd0) && (mem2proc_tag == txn_tag_reg);

  // Pick the access out of a block: offset bits below the access size are
  // dropped, the selected bytes are shifted down and then sign- or
  // zero-extended according to size[2].
  function automatic logic [63:0] extract(input logic [63:0] block,
                                          input logic [2:0]  off,
                                          input logic [2:0]  size);
    logic [2:0]  aoff;
    logic [63:0] word;
    logic [63:0] res;
    case (size[1:0])
      SIZE_BYTE: aoff = off;
      SIZE_HALF: aoff = {off[2:1], 1'b0};
      SIZE_WORD: aoff = {off[2], 2'b00};
      default:   aoff = 3'd0;
    endcase
    word = block >> {aoff, 3'b000};
    case (size[1:0])
      SIZE_BYTE: res = size[2] ? {56'd0, word[7:0]}  : {{56{word[7]}},  word[7:0]};
      SIZE_HALF: res = size[2] ? {48'd0, word[15:0]} : {{48{word[15]}}, word[15:0]};
      SIZE_WORD: res = size[2] ? {32'd0, word[31:0]} : {{32{word[31]}}, word[31:0]};
      default:   res = word;
    endcase
    return res;
  endfunction

  // Control FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      size_reg     <= 3'd0;
      txn_tag_reg  <= 4'd0;
      valid_reg    <= '0;
      finish_reg   <= 1'b0;
      data_reg     <= 64'd0;
      mem_cmd_reg  <= BUS_NONE;
      mem_addr_reg <= '0;
    end else begin
      finish_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (proc2Dcache_command == BUS_LOAD) begin
            addr_reg <= proc2Dcache_addr;
            size_reg <= load_mem_size;
            if (req_hit) begin
              data_reg   <= extract(data_mem[req_idx], proc2Dcache_addr[2:0], load_mem_size);
              finish_reg <= 1'b1;
              state_reg  <= S_RESP;
            end else begin
              mem_cmd_reg  <= BUS_LOAD;
              mem_addr_reg <= {req_tag, req_idx, 3'b000};
              state_reg    <= S_MISS_REQ;
            end
          end
        end

        // Keep asking with a stable address until memory accepts.
        S_MISS_REQ: begin
          if (mem2proc_response != 4'd0) begin
            txn_tag_reg  <= mem2proc_response;
            mem_cmd_reg  <= BUS_NONE;
            mem_addr_reg <= '0;
            state_reg    <= S_MISS_WAIT;
          end
        end

        // Returns carrying other tags belong to someone else; ignore them.
        S_MISS_WAIT: begin
          if (fill_match) begin
            valid_reg[lat_idx] <= 1'b1;
            data_reg           <= extract(mem2proc_data, addr_reg[2:0], size_reg);
            finish_reg         <= 1'b1;
            txn_tag_reg        <= 4'd0;
            state_reg          <= S_RESP;
          end
        end

        S_RESP: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Line fill. A conflicting valid line is simply overwritten: the cache is
  // read-only so there is never anything to write back. The FSM is forced to
  // IDLE while reset is low, so no fill can land during reset.
  always_ff @(posedge clock) begin
    if (state_reg == S_MISS_WAIT && fill_match) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= mem2proc_data;
    end
  end

  assign Dcache2proc_data = data_reg;
  assign finish           = finish_reg;
  assign proc2mem_command = mem_cmd_reg;
  assign proc2mem_addr    = mem_addr_reg;

endmodule

// File: tb/tb_dcache_load_responder.sv
// ---------------------------------------------------------------------------
// tb_dcache_load_responder
//
// Directed bench for dcache_load_responder. A driver walks a schedule of
// loads cycle by cycle and publishes, for every cycle, the outputs the
// block must show; one monitor compares them on the falling edge. Expected
// load values come from a byte-level model of the cache contents, and a few
// hand-computed literals pin that model.
// ---------------------------------------------------------------------------
module tb_dcache_load_responder;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  proc2Dcache_command;
  logic [31:0] proc2Dcache_addr;
  logic [2:0]  load_mem_size;
  logic [63:0] Dcache2proc_data;
  logic        finish;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  always #5 clock = ~clock;

  dcache_load_responder #(.NUM_LINES(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .proc2Dcache_command (proc2Dcache_command),
    .proc2Dcache_addr    (proc2Dcache_addr),
    .load_mem_size       (load_mem_size),
    .Dcache2proc_data    (Dcache2proc_data),
    .finish              (finish),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_data       (mem2proc_data),
    .mem2proc_tag        (mem2proc_tag)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-cycle expectations published by the driver
  logic        exp_finish = 1'b0;
  logic [63:0] exp_data   = 64'd0;
  logic [1:0]  exp_cmd    = BUS_NONE;
  logic [31:0] exp_maddr  = 32'd0;
  bit          mon_en     = 1'b0;

  // Observations gathered by the monitor
  int          finish_seen = 0;
  int          req_cycles  = 0;
  logic [63:0] last_data   = 64'd0;
  logic [31:0] last_maddr  = 32'd0;

  // Cache model: which block address sits at each index, and its bytes
  bit          line_valid [32];
  logic [31:0] line_baddr [32];
  logic [63:0] line_data  [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Byte-oriented extraction: pick nbytes starting at the offset rounded
  // down to the access size, assemble little-endian, then extend.
  function automatic logic [63:0] model_extract(input logic [63:0] blk,
                                                input logic [2:0] off,
                                                input logic [2:0] size);
    int nbytes;
    int start;
    logic [63:0] v;
    nbytes = 1 << size[1:0];
    start  = (int'(off) / nbytes) * nbytes;
    v = 64'd0;
    for (int b = 0; b < nbytes; b++)
      v = v | (64'(blk[8*(start+b) +: 8]) << (8*b));
    if (!size[2] && v[8*nbytes-1])
      for (int b = nbytes; b < 8; b++)
        v = v | (64'hFF << (8*b));
    return v;
  endfunction

  // Monitor: every cycle, compare all outputs against the published values.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("finish",   {63'd0, finish},      {63'd0, exp_finish});
      chk("data",     Dcache2proc_data,     exp_data);
      chk("mem_cmd",  {62'd0, proc2mem_command}, {62'd0, exp_cmd});
      chk("mem_addr", {32'd0, proc2mem_addr},    {32'd0, exp_maddr});
      if (finish === 1'b1) begin
        finish_seen++;
        last_data = Dcache2proc_data;
      end
      if (proc2mem_command === BUS_LOAD) begin
        req_cycles++;
        last_maddr = proc2mem_addr;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One blocking load. Cycle 0 is the request cycle. On a miss the fill
  // request is refused 'retries' times, then accepted with 'rtag'; after
  // 'wait_cyc' cycles carrying 'wrong_tag' (0 = idle bus) the matching data
  // arrives, and finish is due one cycle later.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] size,
                         input int retries, input logic [3:0] rtag,
                         input int wait_cyc, input logic [3:0] wrong_tag,
                         input logic [63:0] fill);
    logic [31:0] baddr;
    int          idx;
    bit          hit;
    baddr = {addr[31:3], 3'b000};
    idx   = int'(addr[7:3]);
    hit   = line_valid[idx] && (line_baddr[idx] == baddr);

    proc2Dcache_command = BUS_LOAD;
    proc2Dcache_addr    = addr;
    load_mem_size       = size;
    exp_finish = 1'b0; exp_cmd = BUS_NONE; exp_maddr = 32'd0;
    step();

    if (!hit) begin
      for (int r = 0; r <= retries; r++) begin
        exp_cmd   = BUS_LOAD;
        exp_maddr = baddr;
        mem2proc_response = (r == retries) ? rtag : 4'd0;
        step();
      end
      mem2proc_response = 4'd0;
      exp_cmd = BUS_NONE; exp_maddr = 32'd0;
      for (int w = 0; w < wait_cyc; w++) begin
        mem2proc_tag  = wrong_tag;
        mem2proc_data = ~fill;
        step();
      end
      mem2proc_tag  = rtag;
      mem2proc_data = fill;
      step();
      mem2proc_tag  = 4'd0;
      mem2proc_data = 64'd0;
      line_valid[idx] = 1'b1;
      line_baddr[idx] = baddr;
      line_data[idx]  = fill;
    end

    exp_finish = 1'b1;
    exp_data   = model_extract(line_data[idx], addr[2:0], size);
    step();
    exp_finish = 1'b0;
    proc2Dcache_command = BUS_NONE;
    $display("load addr=%h size=%b %s data=%h", addr, size, hit ? "hit " : "miss", last_data);
  endtask

  task automatic idle(input int n);
    proc2Dcache_command = BUS_NONE;
    for (int i = 0; i < n; i++) step();
  endtask

  int fin0;
  int req0;

  initial begin
    reset = 1'b0;
    proc2Dcache_command = BUS_NONE;
    proc2Dcache_addr    = 32'd0;
    load_mem_size       = 3'd0;
    mem2proc_response   = 4'd0;
    mem2proc_data       = 64'd0;
    mem2proc_tag        = 4'd0;
    foreach (line_valid[i]) line_valid[i] = 1'b0;
    mon_en = 1'b1;
    step();
    step();
    reset = 1'b1;
    chk("rst_data",   Dcache2proc_data, 64'd0);
    chk("rst_finish", {63'd0, finish}, 64'd0);
    chk("rst_memcmd", {62'd0, proc2mem_command}, 64'd0);
    step();

    // Cold miss, accepted after two refusals
    fin0 = finish_seen;
    do_load(32'h0000_0104, 3'b010, 2, 4'd3, 2, 4'd0, 64'h1122_3344_8899_AABB);
    chk("cold_addr",  {32'd0, last_maddr}, 64'h0000_0000_0000_0100);
    chk("cold_data",  last_data, 64'h0000_0000_1122_3344);
    chk("cold_nfin",  64'(finish_seen - fin0), 64'd1);

    // Hits back to back, various sizes
    req0 = req_cycles;
    do_load(32'h0000_0100, 3'b010, 0, 4'd0, 0, 4'd0, 64'd0);
    chk("hit_w_lo",   last_data, 64'hFFFF_FFFF_8899_AABB);
    do_load(32'h0000_0104, 3'b110, 0, 4'd0, 0, 4'd0, 64'd0);
    chk("hit_wu",     last_data, 64'h0000_0000_1122_3344);
    do_load(32'h0000_0100, 3'b110, 0, 4'd0, 0, 4'd0, 64'd0);
    chk("hit_wu_lo",  last_data, 64'h0000_0000_8899_AABB);
    do_load(32'h0000_0103, 3'b000, 0, 4'd0, 0, 4'd0, 64'd0);
    chk("hit_byte",   last_data, 64'hFFFF_FFFF_FFFF_FF88);
    do_load(32'h0000_0103, 3'b001, 0, 4'd0, 0, 4'd0, 64'd0);
    chk("hit_half",   last_data, 64'hFFFF_FFFF_FFFF_8899);
    do_load(32'h0000_0105, 3'b101, 0, 4'd0, 0, 4'd0, 64'd0);
    do_load(32'h0000_0107, 3'b000, 0, 4'd0, 0, 4'd0, 64'd0);
    do_load(32'h0000_0106, 3'b011, 0, 4'd0, 0, 4'd0, 64'd0);
    chk("hit_dbl",    last_data, 64'h1122_3344_8899_AABB);
    chk("hit_nomem",  64'(req_cycles - req0), 64'd0);
    idle(2);

    // Conflict: same index, new tag, then the original block misses again
    do_load(32'h0000_0204, 3'b010, 0, 4'd1, 1, 4'd0, 64'hCAFE_BABE_DEAD_BEEF);
    chk("conf_data",  last_data, 64'hFFFF_FFFF_CAFE_BABE);
    req0 = req_cycles;
    do_load(32'h0000_0104, 3'b010, 0, 4'd2, 0, 4'd0, 64'h1122_3344_8899_AABB);
    chk("conf_remiss", 64'(req_cycles - req0), 64'd1);
    chk("conf_addr",  {32'd0, last_maddr}, 64'h0000_0000_0000_0100);

    // Tag filter: tag 2 traffic while waiting on tag 5
    fin0 = finish_seen;
    do_load(32'h0000_02A8, 3'b011, 0, 4'd5, 3, 4'd2, 64'h0123_4567_89AB_CDEF);
    chk("tag_data",   last_data, 64'h0123_4567_89AB_CDEF);
    chk("tag_nfin",   64'(finish_seen - fin0), 64'd1);

    // Retry: four refusals, accepted on the fifth request cycle
    req0 = req_cycles;
    do_load(32'h0000_03F0, 3'b001, 4, 4'd7, 0, 4'd0, 64'h0000_0000_0000_F00D);
    chk("retry_cyc",  64'(req_cycles - req0), 64'd5);
    chk("retry_data", last_data, 64'hFFFF_FFFF_FFFF_F00D);
    idle(1);

    // Reset while waiting for fill data, then a late return with that tag
    fin0 = finish_seen;
    proc2Dcache_command = BUS_LOAD;
    proc2Dcache_addr    = 32'h0000_0340;
    load_mem_size       = 3'b011;
    exp_finish = 1'b0; exp_cmd = BUS_NONE; exp_maddr = 32'd0;
    step();
    exp_cmd = BUS_LOAD; exp_maddr = 32'h0000_0340;
    mem2proc_response = 4'd6;
    step();
    mem2proc_response = 4'd0;
    exp_cmd = BUS_NONE; exp_maddr = 32'd0;
    step();
    reset = 1'b0;
    proc2Dcache_command = BUS_NONE;
    exp_data = 64'd0;
    foreach (line_valid[i]) line_valid[i] = 1'b0;
    step();
    step();
    reset = 1'b1;
    mem2proc_tag  = 4'd6;
    mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    step();
    mem2proc_tag  = 4'd0;
    mem2proc_data = 64'd0;
    chk("rst_nofin",  64'(finish_seen - fin0), 64'd0);
    $display("reset during fill, late tag 6 returned");
    req0 = req_cycles;
    do_load(32'h0000_0100, 3'b010, 0, 4'd4, 0, 4'd0, 64'h1122_3344_8899_AABB);
    chk("rst_remiss", 64'(req_cycles - req0), 64'd1);
    chk("rst_data2",  last_data, 64'hFFFF_FFFF_8899_AABB);
    idle(3);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
